// File: rtl/dm_arb_pkg.sv
// Shared types and default constants for the data-memory port arbiter.
package dm_arb_pkg;

    typedef enum logic {
        NORMAL = 1'b0,
        BOOST  = 1'b1
    } arb_state_e;

    typedef enum logic {
        OWN_PIPE = 1'b0,
        OWN_DBG  = 1'b1
    } owner_e;

    localparam logic [2:0] OP_WORD_DEF    = 3'd0;
    localparam int         STARVE_MAX_DEF = 8;

endpackage

// File: rtl/dm_arb_starve.sv
// Debug starvation counter plus NORMAL/BOOST priority FSM.
// Optional macro DM_ARB_STATS_EN exposes a one-cycle BOOST-entry strobe.
module dm_arb_starve
    import dm_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic d_req,
    input  logic d_gnt,
`ifdef DM_ARB_STATS_EN
    output logic boost_enter,
`endif
    output logic force_dbg
);

    localparam int CNT_W = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(STARVE_MAX - 1);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic             enter_boost;

    // Next-state: count denied debug cycles, escalate to BOOST on the last one.
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        enter_boost  = 1'b0;
        if (en) begin
            if (d_gnt || !d_req) begin
                starve_cnt_d = '0;
            end else if (starve_cnt_q != CNT_TOP) begin
                starve_cnt_d = starve_cnt_q + CNT_W'(1);
            end
            case (state_q)
                NORMAL: begin
                    if (d_req && !d_gnt && (starve_cnt_q == CNT_TOP)) begin
                        state_d     = BOOST;
                        enter_boost = 1'b1;
                    end
                end
                BOOST:   state_d = NORMAL;
                default: state_d = NORMAL;
            endcase
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= NORMAL;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign force_dbg = (state_q == BOOST);

`ifdef DM_ARB_STATS_EN
    assign boost_enter = enter_boost;
`endif

endmodule

// File: rtl/dm_port_arbiter.sv
// Two-requester arbiter for the single synchronous data memory.
// Optional macro DM_ARB_STATS_EN adds conflict/BOOST-entry counters.
module dm_port_arbiter
    import dm_arb_pkg::*;
#(
    parameter int              ADDR_W     = 10,
    parameter int              OP_W       = 3,
    parameter logic [OP_W-1:0] OP_WORD    = OP_WORD_DEF,
    parameter int              STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              p_req,
    input  logic              p_we,
    input  logic [OP_W-1:0]   p_op,
    input  logic [ADDR_W+1:0] p_addr,
    input  logic [31:0]       p_wdata,
    output logic              p_stall,
    output logic              p_rvalid,
    output logic [31:0]       p_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              m_en,
    output logic              m_we,
    output logic [OP_W-1:0]   m_op,
    output logic [ADDR_W+1:0] m_addr,
    output logic [31:0]       m_wdata,
`ifdef DM_ARB_STATS_EN
    output logic [31:0]       stat_conflict,
    output logic [31:0]       stat_boost,
`endif
    input  logic [31:0]       m_rdata
);

    logic   active;
    logic   force_dbg;
    logic   p_gnt;
    logic   rvalid_q, rvalid_d;
    owner_e rd_owner_q, rd_owner_d;

    // Reset forces the combinational handshake outputs low as well.
    assign active = en & ~rst;

`ifdef DM_ARB_STATS_EN
    logic boost_enter;
`endif

    dm_arb_starve #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .d_req       (d_req),
        .d_gnt       (d_gnt),
`ifdef DM_ARB_STATS_EN
        .boost_enter (boost_enter),
`endif
        .force_dbg   (force_dbg)
    );

    // Grant decision and memory-port steering from the winner.
    always_comb begin
        d_gnt   = active & d_req & (force_dbg | ~p_req);
        p_gnt   = active & p_req & ~d_gnt;
        p_stall = active & p_req & ~p_gnt;
        m_en    = 1'b0;
        m_we    = 1'b0;
        m_op    = '0;
        m_addr  = '0;
        m_wdata = '0;
        if (d_gnt) begin
            m_en    = 1'b1;
            m_we    = d_we;
            m_op    = OP_WORD;
            m_addr  = {d_addr, 2'b00};
            m_wdata = d_wdata;
        end else if (p_gnt) begin
            m_en    = 1'b1;
            m_we    = p_we;
            m_op    = p_op;
            m_addr  = p_addr;
            m_wdata = p_wdata;
        end
    end

    // Remember who issued a granted read so the data returns to them.
    always_comb begin
        rvalid_d   = rvalid_q;
        rd_owner_d = rd_owner_q;
        if (en) begin
            rvalid_d = m_en & ~m_we;
            if (m_en) begin
                rd_owner_d = d_gnt ? OWN_DBG : OWN_PIPE;
            end
        end
    end

    // Read-return registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_q   <= 1'b0;
            rd_owner_q <= OWN_PIPE;
        end else begin
            rvalid_q   <= rvalid_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    assign p_rvalid = rvalid_q & (rd_owner_q == OWN_PIPE);
    assign d_rvalid = rvalid_q & (rd_owner_q == OWN_DBG);
    assign p_rdata  = m_rdata;
    assign d_rdata  = m_rdata;

`ifdef DM_ARB_STATS_EN
    logic [31:0] stat_conflict_q, stat_conflict_d;
    logic [31:0] stat_boost_q, stat_boost_d;

    // Statistics next-state: both counters frozen while disabled.
    always_comb begin
        stat_conflict_d = stat_conflict_q;
        stat_boost_d    = stat_boost_q;
        if (en) begin
            if (p_req && d_req) stat_conflict_d = stat_conflict_q + 32'd1;
            if (boost_enter)    stat_boost_d    = stat_boost_q + 32'd1;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_conflict_q <= '0;
            stat_boost_q    <= '0;
        end else begin
            stat_conflict_q <= stat_conflict_d;
            stat_boost_q    <= stat_boost_d;
        end
    end

    assign stat_conflict = stat_conflict_q;
    assign stat_boost    = stat_boost_q;
`endif

endmodule

// File: doc/dm_port_arbiter.md
Name: dm_port_arbiter

Overview:
- Shares the single synchronous data memory between two requesters: the pipeline's memory-access stage and the debug/loader master.
- Issues at most one access per cycle and stalls the pipeline on conflict.
- Guarantees forward progress for the debug master with a starvation counter.
- Returns read data one cycle after grant, routed to the owner of the access.

Parameters:
ADDR_W, 10, word-address width of data memory
OP_W, 3, width of memory op code
OP_WORD, 3'd0, op code issued for debug-master accesses (full word)
STARVE_MAX, 8, consecutive denied debug-request cycles before debug is forced to win

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
en  in  1  global enable; low freezes all state, no grants
p_req  in  1  pipeline requests access this cycle
p_we  in  1  pipeline write
p_op  in  OP_W  pipeline op (byte/half/word, sign)
p_addr  in  ADDR_W+2  pipeline byte address
p_wdata  in  32  pipeline store data
p_stall  out  1  pipeline request not granted this cycle
p_rvalid  out  1  pipeline read data valid
p_rdata  out  32  pipeline read data
d_req  in  1  debug master request; held stable until d_gnt
d_we  in  1  debug write
d_addr  in  ADDR_W  debug word address
d_wdata  in  32  debug write data
d_gnt  out  1  debug request accepted this cycle
d_rvalid  out  1  debug read data valid
d_rdata  out  32  debug read data
m_en, m_we  out  1  memory enable / write enable
m_op  out  OP_W  memory op
m_addr  out  ADDR_W+2  memory byte address
m_wdata  out  32  memory write data
m_rdata  in  32  memory read data, valid cycle after m_en read

Behaviour:
- Reset (async, rst=1): state NORMAL, starve_cnt=0, rd_owner=0, p_rvalid=d_rvalid=0.
- Combinational outputs while rst=1: p_stall=0, d_gnt=0, m_en=0.
- en=0: no grants, m_en=0, p_stall=0, state/counter/rvalids hold.
- FSM NORMAL: pipeline has priority; d_gnt = d_req & ~p_req.
- FSM BOOST: debug has priority; d_gnt = d_req, pipeline stalls if p_req.
- NORMAL -> BOOST: d_req & ~d_gnt & starve_cnt == STARVE_MAX-1.
- BOOST -> NORMAL: unconditionally next cycle; d_req is held, so the debug access always completes.
- starve_cnt: +1 each en cycle with d_req & ~d_gnt; cleared on d_gnt or ~d_req; saturates at STARVE_MAX-1.
- p_stall = en & p_req & ~p_gnt, combinational, same cycle.
- Grant drives m_* combinationally from the winner.
- Debug address mapping: m_addr = {d_addr, 2'b00}, m_op = OP_WORD.
- m_en=0 when no grant.
- Read return:
  - Granted read sets rd_owner and the matching rvalid next cycle.
  - *_rdata = m_rdata; the non-owner's rdata is undefined, so the bench checks rdata only with rvalid.
  - Writes produce no rvalid.
- Latency: grant 0 cycles (combinational), read data 1 cycle.
- Back-to-back reads from alternating owners are legal every cycle.
- Simultaneous p_req & d_req: resolved per FSM state above; never two accesses per cycle.
- Reset mid-read: pending rvalid dropped; no rvalid after reset release.
- p_req with en=0 is ignored, not queued.

Optional Feature:
- Macro: DM_ARB_STATS_EN.
- Defined:
  - Adds outputs stat_conflict[31:0] (cycles with p_req & d_req & en) and stat_boost[31:0] (BOOST entries).
  - Both counters reset to 0, wrap at 2^32, and freeze when en=0.
- Undefined: ports and counters absent, no logic.

Decomposition:
- Shared package dm_arb_pkg holds:
  - state enum {NORMAL, BOOST}
  - owner encoding {OWN_PIPE=0, OWN_DBG=1}
  - OP_WORD default
  - STARVE_MAX default
- Sub-module dm_arb_starve: counter plus NORMAL/BOOST FSM, output force_dbg.
- Top level holds the muxing and read-return registers.

Test Plan:
- Pipeline only: p_req read addr 0x010 (memory preloaded 0xDEADBEEF) -> p_stall=0, next cycle p_rvalid=1, p_rdata=0xDEADBEEF, d_rvalid=0.
- Debug only: d_req write d_addr=5 data 0x12345678, then read d_addr=5 -> d_gnt both cycles, m_addr=0x014, m_op=OP_WORD, d_rdata=0x12345678 one cycle after the read grant.
- Conflict: p_req and d_req both high for 1 cycle with STARVE_MAX=8 -> pipeline granted, d_gnt=0, p_stall=0; the next cycle, with p_req low, gives d_gnt=1.
- Starvation: p_req held high for 20 cycles, d_req high from cycle 0 with STARVE_MAX=8 -> d_gnt and p_stall=1 exactly at cycle 8, pipeline granted at cycle 9.
- Reset mid-read: read granted at cycle N, rst pulses asynchronously before edge N+1 -> p_rvalid=0, starve_cnt=0, FSM NORMAL.
- en low: en=0 with both requests for 4 cycles -> m_en=0, p_stall=0, d_gnt=0, starve_cnt unchanged; with DM_ARB_STATS_EN defined, stat_conflict unchanged.
